// File: rtl/cfs_apb_slv_pkg.sv
// Shared types and constants for the cfs_apb_slave APB completer.
package cfs_apb_slv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP_SEEN,
    ACCESS
  } cfs_apb_slv_state_e;

  localparam logic [31:0] CFS_APB_SLV_ID_DEFAULT = 32'hCF5A_0001;
  localparam int          CFS_APB_SLV_WCNT_W     = 4;

endpackage

// File: rtl/cfs_apb_slv_regfile.sv
// Register bank: read-only ID word at index 0, RW words at 1..NUM_REGS,
// combinational read mux and decode-error flag.
module cfs_apb_slv_regfile
  import cfs_apb_slv_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                IDX_W    = 14,
  parameter int                NUM_REGS = 4,
  parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(CFS_APB_SLV_ID_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IDX_W-1:0]           idx,
  input  logic                       write,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       err,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              is_id;
  logic              is_rw;

  assign is_id = (idx == '0);
  assign is_rw = !is_id && (idx <= IDX_W'(NUM_REGS));
  // Writing the ID word and touching anything past the bank are both errors.
  assign err   = (is_id && write) || (!is_id && !is_rw);

  always_comb begin
    rd_data = '0;
    if (is_id) begin
      rd_data = ID_VALUE;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i + 1)) begin
        rd_data = regs_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en && is_rw) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx == IDX_W'(i + 1)) begin
          regs_q[i] <= wdata;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    assign regs_flat[gi*DATA_W +: DATA_W] = regs_q[gi];
  end

endmodule

// File: rtl/cfs_apb_slave.sv
// APB completer with optional wait states and a small register bank.
// Wait-state counter is built only when CFS_APB_SLV_WAIT_EN is defined.
module cfs_apb_slave
  import cfs_apb_slv_pkg::*;
#(
  parameter int    CFS_APB_MAX_ADDR_WIDTH = 16,
  parameter int    CFS_APB_MAX_DATA_WIDTH = 32,
  parameter int    NUM_REGS               = 4,
  parameter int    WAIT_CYCLES            = 0,
  parameter logic [CFS_APB_MAX_DATA_WIDTH-1:0] ID_VALUE =
    CFS_APB_MAX_DATA_WIDTH'(CFS_APB_SLV_ID_DEFAULT)
) (
  input  logic                                       pclk,
  input  logic                                       preset,
  input  logic                                       psel,
  input  logic                                       penable,
  input  logic                                       pwrite,
  input  logic [CFS_APB_MAX_ADDR_WIDTH-1:0]          paddr,
  input  logic [CFS_APB_MAX_DATA_WIDTH-1:0]          pwdata,
  output logic                                       pready,
  output logic [CFS_APB_MAX_DATA_WIDTH-1:0]          prdata,
  output logic                                       pslverr,
  output logic [NUM_REGS*CFS_APB_MAX_DATA_WIDTH-1:0] regs_o
);

  localparam int ADDR_W = CFS_APB_MAX_ADDR_WIDTH;
  localparam int DATA_W = CFS_APB_MAX_DATA_WIDTH;
  localparam int IDX_W  = ADDR_W - 2;

  cfs_apb_slv_state_e state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               pwrite_q;
  logic               pready_q, pready_d;
  logic               pslverr_q, pslverr_d;
  logic [DATA_W-1:0]  prdata_q, prdata_d;

  logic               setup, busy, commit;
  logic               first_done, wait_last;
  logic [IDX_W-1:0]   cur_idx;
  logic               cur_write;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_err;

  assign setup     = psel && !penable;
  assign busy      = (state_q != IDLE);
  // In IDLE the live address feeds the decode so a zero-wait response can
  // be registered on the setup edge itself.
  assign cur_idx   = busy ? idx_q : paddr[ADDR_W-1:2];
  assign cur_write = busy ? pwrite_q : pwrite;
  assign commit    = busy && psel && penable && pready_q && pwrite_q;

`ifdef CFS_APB_SLV_WAIT_EN
  logic [CFS_APB_SLV_WCNT_W-1:0] wcnt_q;

  assign first_done = (WAIT_CYCLES == 0);
  assign wait_last  = (wcnt_q == CFS_APB_SLV_WCNT_W'(1));

  always_ff @(posedge pclk) begin
    if (preset) begin
      wcnt_q <= '0;
    end else if (!busy && setup) begin
      wcnt_q <= CFS_APB_SLV_WCNT_W'(WAIT_CYCLES);
    end else if (busy && psel && (wcnt_q != '0)) begin
      wcnt_q <= wcnt_q - CFS_APB_SLV_WCNT_W'(1);
    end
  end
`else
  logic unused_wait;

  assign first_done  = 1'b1;
  assign wait_last   = 1'b0;
  assign unused_wait = &{1'b0, (WAIT_CYCLES != 0)};
`endif

  logic unused_addr;
  assign unused_addr = &{1'b0, paddr[1:0]};

  cfs_apb_slv_regfile #(
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W),
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk       (pclk),
    .rst       (preset),
    .idx       (cur_idx),
    .write     (cur_write),
    .wr_en     (commit),
    .wdata     (pwdata),
    .rd_data   (rd_data),
    .err       (rd_err),
    .regs_flat (regs_o)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (!busy && setup) begin
      idx_q    <= paddr[ADDR_W-1:2];
      pwrite_q <= pwrite;
    end
  end

  always_comb begin
    state_d   = state_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          state_d  = SETUP_SEEN;
          pready_d = first_done;
        end
      end
      SETUP_SEEN, ACCESS: begin
        if (!psel || pready_q) begin
          state_d = IDLE;
        end else begin
          state_d  = ACCESS;
          pready_d = wait_last;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pready_d) begin
      prdata_d  = rd_data;
      pslverr_d = rd_err;
    end
  end

  assign pready  = pready_q;
  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_cfs_apb_slave.sv
// Scoreboard bench for cfs_apb_slave: directed APB transfers push expected
// responses; a negedge monitor pops and compares on every pready.
module tb_cfs_apb_slave;

`ifdef CFS_APB_SLV_WAIT_EN
  localparam int EW = 3;
`else
  localparam int EW = 0;
`endif
  localparam logic [31:0] ID = 32'hCF5A_0001;

  logic         pclk = 1'b0;
  logic         preset;
  logic         psel, penable, pwrite;
  logic [15:0]  paddr;
  logic [31:0]  pwdata;
  logic         pready;
  logic [31:0]  prdata;
  logic         pslverr;
  logic [127:0] regs_o;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        wr;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic mon_off  = 1'b0;
  logic pready_prev = 1'b0;

  cfs_apb_slave #(
    .CFS_APB_MAX_ADDR_WIDTH (16),
    .CFS_APB_MAX_DATA_WIDTH (32),
    .NUM_REGS               (4),
    .WAIT_CYCLES            (3),
    .ID_VALUE               (32'hCF5A_0001)
  ) dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pready  (pready),
    .prdata  (prdata),
    .pslverr (pslverr),
    .regs_o  (regs_o)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expected response per pready pulse.
  always @(negedge pclk) begin
    if (!mon_off && !preset) begin
      if (pready) begin
        checks++;
        if (pready_prev) begin
          failures++;
          $display("FAIL pready_width actual=2+ cycles required=1");
        end
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pready actual=1 required=0 at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          if (pslverr !== e.err) begin
            failures++;
            $display("FAIL pslverr actual=%0b required=%0b", pslverr, e.err);
          end
          checks++;
          if ((cyc - e.cyc) != 1 + EW) begin
            failures++;
            $display("FAIL latency actual=%0d required=%0d", cyc - e.cyc, 1 + EW);
          end
          if (!e.wr) begin
            checks++;
            if (prdata !== e.rd) begin
              failures++;
              $display("FAIL prdata actual=%08h required=%08h", prdata, e.rd);
            end
          end
        end
      end else begin
        checks++;
        if (pslverr !== 1'b0) begin
          failures++;
          $display("FAIL pslverr_idle actual=%0b required=0", pslverr);
        end
      end
    end
    pready_prev = pready;
  end

  // Entered and left at #1 after a posedge, so consecutive calls are back-to-back.
  task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eerr);
    int n;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = ~wd;
    exp_q.push_back('{rd: erd, err: eerr, wr: wr, cyc: cyc});
    @(posedge pclk); #1;
    penable = 1'b1; pwdata = wd;
    n = 0;
    while (!pready && n < 50) begin
      @(posedge pclk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL pready_timeout addr=%04h actual=0 required=1", a);
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; preset = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;
    check("rst_pready", 128'(pready), 128'(0));
    check("rst_prdata", 128'(prdata), 128'(0));
    check("rst_pslverr", 128'(pslverr), 128'(0));
    check("rst_regs", regs_o, 128'(0));

    xfer(1, 16'h0004, 32'h5555_AAAA, 32'h0, 0);
    xfer(0, 16'h0004, 32'h0, 32'h5555_AAAA, 0);
    check("pre_reset_reg1", 128'(regs_o[31:0]), 128'(32'h5555_AAAA));

    // Reset in the middle of a write to index 2.
    mon_off = 1'b1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0008; pwdata = 32'h77;
    @(posedge pclk); #1;
    penable = 1'b1; preset = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    check("midrst_pready", 128'(pready), 128'(0));
    check("midrst_prdata", 128'(prdata), 128'(0));
    check("midrst_pslverr", 128'(pslverr), 128'(0));
    check("midrst_regs", regs_o, 128'(0));
    @(posedge pclk); #1;
    mon_off = 1'b0;

    xfer(1, 16'h0004, 32'hDEAD_BEEF, 32'h0, 0);
    xfer(0, 16'h0004, 32'h0, 32'hDEAD_BEEF, 0);
    check("reg1_deadbeef", 128'(regs_o[31:0]), 128'(32'hDEAD_BEEF));

    xfer(0, 16'h0000, 32'h0, ID, 0);
    xfer(1, 16'h0000, 32'h0000_FFFF, 32'h0, 1);
    xfer(0, 16'h0000, 32'h0, ID, 0);
    xfer(0, 16'h0014, 32'h0, 32'h0, 1);
    xfer(1, 16'h0014, 32'h0000_0BAD, 32'h0, 1);
    check("regs_after_errs", regs_o, {96'h0, 32'hDEAD_BEEF});

    // Access phase with no preceding setup must be ignored.
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 16'h0008; pwdata = 32'h0BAD_0BAD;
    repeat (3) @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0;
    check("no_setup_reg2", 128'(regs_o[63:32]), 128'(0));
    @(posedge pclk); #1;

`ifdef CFS_APB_SLV_WAIT_EN
    // Abort during a wait state.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0008; pwdata = 32'h1234;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    check("abort_reg2", 128'(regs_o[63:32]), 128'(0));
`endif
    xfer(0, 16'h0008, 32'h0, 32'h0, 0);

    xfer(1, 16'h0004, 32'h0000_0001, 32'h0, 0);
    xfer(1, 16'h0008, 32'h0000_0002, 32'h0, 0);
    xfer(1, 16'h000C, 32'h0000_0003, 32'h0, 0);
    xfer(1, 16'h0006, 32'h0000_0004, 32'h0, 0);
    check("b2b_regs", regs_o, {32'h0, 32'h3, 32'h2, 32'h4});
    xfer(0, 16'h0004, 32'h0, 32'h4, 0);
    xfer(0, 16'h0008, 32'h0, 32'h2, 0);
    xfer(0, 16'h000C, 32'h0, 32'h3, 0);
    xfer(0, 16'h0010, 32'h0, 32'h0, 0);
    xfer(1, 16'h0010, 32'hA5A5_5A5A, 32'h0, 0);
    xfer(0, 16'h0010, 32'h0, 32'hA5A5_5A5A, 0);
    check("reg4_final", 128'(regs_o[127:96]), 128'(32'hA5A5_5A5A));

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge pclk);
    #1;
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
